trace_cmd_dispatcher: RTL and testbench
=======================================

// Module: trace_cmd_dispatcher
// PURPOSE
//  Sits directly downstream of the trace-file reader. Accepts {command, address} pairs,
//  buffers them in an in-order FIFO, and decodes each one. Each command is routed to exactly one of
//  three destinations: the L1 request port, the shared-bus snoop port, or the clear/print control
//  pulses. It also keeps saturating statistics counters. Routing never reorders commands.
// PARAMETERS
//  ADDR_W   32  address width
//  DEPTH     8  command FIFO entries (power of 2, >=2)
//  CNT_W    32  width of each statistics counter
// PORTS
//  clk            in   1       single clock, all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  cmd_valid      in   1       upstream command present
//  cmd_ready      out  1       = !fifo_full; transfer when cmd_valid & cmd_ready
//  cmd            in   4       trace command code 0-9
//  cmd_addr       in   ADDR_W  trace address
//  l1_valid       out  1       L1 request valid (registered)
//  l1_ready       in   1       cache controller accepts L1 request
//  l1_op          out  2       0=DR data read, 1=DW data write, 2=IR instr read
//  l1_addr        out  ADDR_W  L1 request address
//  snp_valid      out  1       snoop request valid (registered)
//  snp_ready      in   1       cache controller accepts snoop
//  snp_op         out  2       0=I invalidate, 1=R read, 2=W write, 3=M RWITM
//  snp_addr       out  ADDR_W  snoop address
//  ctl_clear      out  1       one-cycle pulse, command 8
//  ctl_print      out  1       one-cycle pulse, command 9
//  rd_cnt         out  CNT_W   completed DR+IR dispatches
//  wr_cnt         out  CNT_W   completed DW dispatches
//  snp_cnt        out  CNT_W   completed snoop dispatches
//  err_cnt        out  CNT_W   dropped illegal codes (7, 10-15)
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE, all outputs 0 (cmd_ready=1 the cycle after rst drops).
//   Counters are 0. In-flight and buffered commands are discarded; no ctl pulse is emitted.
//  FIFO: push on cmd_valid&cmd_ready. No push while full, even if a pop occurs in the same cycle.
//   Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH+1).
//  FSM states: IDLE, L1_WAIT, SNP_WAIT.
//   IDLE & FIFO non-empty: pop head and decode it.
//    0/1/2: load l1_op/l1_addr, l1_valid<=1, go to L1_WAIT.
//    3-6: load snp_op/snp_addr, snp_valid<=1, go to SNP_WAIT.
//    8: ctl_clear<=1 for exactly one cycle, stay IDLE.
//    9: ctl_print<=1 for exactly one cycle, stay IDLE.
//    illegal code: err_cnt++, stay IDLE.
//   L1_WAIT: hold l1_valid/op/addr stable until l1_valid&l1_ready.
//    On that edge, increment rd_cnt or wr_cnt.
//    If the FIFO is non-empty, pop and decode the next command on the same edge (back-to-back).
//    If the FIFO is empty, l1_valid<=0 and go to IDLE.
//   SNP_WAIT: same as L1_WAIT, using snp_* signals and snp_cnt.
//  Latency: command accepted at edge N gives a valid output or ctl pulse after edge N+1, provided
//   the FSM was IDLE with the FIFO empty. Sustained throughput is 1 command/cycle when ready is held 1.
//  l1_valid and snp_valid are never high simultaneously. Neither valid is high in a ctl-pulse cycle.
//  Ready inputs are ignored while the corresponding valid is low.
//  Counters saturate at all-ones; they never wrap.
//  Simultaneous push and pop when not full: both take effect; occupancy is unchanged.
// TESTING
//  1 Reset, push {0,0x1000}, hold l1_ready=1 -> l1_valid after 2 edges, op=0, addr=0x1000, rd_cnt=1
//  2 Push 3,4,5,6 @0xA0..0xA3 with snp_ready=0 for 5 cycles, then 1
//    -> snp_op 0,1,2,3 in order, addr stable while stalled, snp_cnt=4
//  3 Push 9 commands with both ready=0, DEPTH=8 -> cmd_ready=0 after 8th buffered; drain -> all 9 in order
//  4 Push 1,8,2,9,7 -> DW, clear pulse 1 cycle, IR, print pulse, err_cnt=1, wr_cnt=1, rd_cnt=1
//  5 Assert rst while in L1_WAIT with 3 buffered -> next cycle all valids 0, counters 0, FIFO empty
//  6 Force CNT_W=4, issue 20 reads -> rd_cnt saturates at 15

Source files
------------

// File: rtl/trace_cmd_dispatcher.sv
// Trace command dispatcher: in-order command FIFO feeding a decode FSM that routes each
// command to the L1 request port, the snoop port, or a clear/print pulse, with saturating
// statistics counters.
module trace_cmd_dispatcher #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              l1_valid,
  input  logic              l1_ready,
  output logic [1:0]        l1_op,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              snp_valid,
  input  logic              snp_ready,
  output logic [1:0]        snp_op,
  output logic [ADDR_W-1:0] snp_addr,
  output logic              ctl_clear,
  output logic              ctl_print,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  snp_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    L1_WAIT,
    SNP_WAIT
  } state_t;

  state_t state;

  logic [ADDR_W+3:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic              push;
  logic              pop;
  logic              empty;
  logic              l1_done;
  logic              snp_done;
  logic [3:0]        head_cmd;
  logic [ADDR_W-1:0] head_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshakes, pop decision and next occupancy
  always_comb begin
    empty    = (occ == '0);
    push     = cmd_valid & cmd_ready;
    l1_done  = (state == L1_WAIT) & l1_ready;
    snp_done = (state == SNP_WAIT) & snp_ready;
    pop      = !empty & ((state == IDLE) | l1_done | snp_done);
    {head_cmd, head_addr} = mem[rptr];
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + OCC_W'(1);
    end else if (pop && !push) begin
      occ_next = occ - OCC_W'(1);
    end
  end

  // FIFO storage (no reset needed, guarded by occupancy)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {cmd, cmd_addr};
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      occ       <= occ_next;
      cmd_ready <= (occ_next != OCC_W'(DEPTH));
    end
  end

  // Dispatch FSM; a completed handshake retires first, then a same-edge pop overrides outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      l1_valid  <= 1'b0;
      l1_op     <= '0;
      l1_addr   <= '0;
      snp_valid <= 1'b0;
      snp_op    <= '0;
      snp_addr  <= '0;
      ctl_clear <= 1'b0;
      ctl_print <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      snp_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      ctl_clear <= 1'b0;
      ctl_print <= 1'b0;
      if (l1_done) begin
        if (l1_op == 2'd1) begin
          wr_cnt <= sat_inc(wr_cnt);
        end else begin
          rd_cnt <= sat_inc(rd_cnt);
        end
      end
      if (snp_done) begin
        snp_cnt <= sat_inc(snp_cnt);
      end
      if (l1_done || snp_done) begin
        l1_valid  <= 1'b0;
        snp_valid <= 1'b0;
        state     <= IDLE;
      end
      if (pop) begin
        case (head_cmd)
          4'd0, 4'd1, 4'd2: begin
            l1_valid <= 1'b1;
            l1_op    <= head_cmd[1:0];
            l1_addr  <= head_addr;
            state    <= L1_WAIT;
          end
          4'd3, 4'd4, 4'd5, 4'd6: begin
            snp_valid <= 1'b1;
            snp_op    <= 2'(head_cmd - 4'd3);
            snp_addr  <= head_addr;
            state     <= SNP_WAIT;
          end
          4'd8: ctl_clear <= 1'b1;
          4'd9: ctl_print <= 1'b1;
          default: err_cnt <= sat_inc(err_cnt);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// Self-checking bench for trace_cmd_dispatcher: directed scenarios plus a randomized stream,
// checked against an in-order queue of expected dispatches and saturating counter model.
`timescale 1ns/1ps
module tb_trace_cmd_dispatcher;

  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic              l1_valid;
  logic              l1_ready;
  logic [1:0]        l1_op;
  logic [ADDR_W-1:0] l1_addr;
  logic              snp_valid;
  logic              snp_ready;
  logic [1:0]        snp_op;
  logic [ADDR_W-1:0] snp_addr;
  logic              ctl_clear;
  logic              ctl_print;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  snp_cnt;
  logic [CNT_W-1:0]  err_cnt;

  always #5 clk = ~clk;

  trace_cmd_dispatcher #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .cmd_addr (cmd_addr),
    .l1_valid (l1_valid),
    .l1_ready (l1_ready),
    .l1_op    (l1_op),
    .l1_addr  (l1_addr),
    .snp_valid(snp_valid),
    .snp_ready(snp_ready),
    .snp_op   (snp_op),
    .snp_addr (snp_addr),
    .ctl_clear(ctl_clear),
    .ctl_print(ctl_print),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .snp_cnt  (snp_cnt),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    logic [3:0]        code;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_rd, m_wr, m_snp, m_err;
  int l1_mode, snp_mode;   // 0 = hold low, 1 = hold high, 2 = random
  bit acc;
  bit hold_l1, hold_snp;
  logic [1:0]        h_l1_op, h_snp_op;
  logic [ADDR_W-1:0] h_l1_addr, h_snp_addr;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic bit legal(input logic [3:0] c);
    return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic consume(input logic [3:0] code, input logic [ADDR_W-1:0] addr,
                         input bit has_addr, output logic [3:0] ecode);
    ent_t e;
    if (exp_q.size() == 0) begin
      ecode = 4'hF;
      check("unexpected_dispatch", 64'(code), 64'hFF);
      return;
    end
    e = exp_q.pop_front();
    ecode = e.code;
    check("dispatch_code", 64'(code), 64'(e.code));
    if (has_addr) check("dispatch_addr", 64'(addr), 64'(e.addr));
  endtask

  task automatic observe();
    logic [3:0] ec;
    acc = 1'b0;
    if (rst) begin
      hold_l1  = 1'b0;
      hold_snp = 1'b0;
      return;
    end
    check("rd_cnt", 64'(rd_cnt), 64'(m_rd));
    check("wr_cnt", 64'(wr_cnt), 64'(m_wr));
    check("snp_cnt", 64'(snp_cnt), 64'(m_snp));
    check("valid_excl", 64'(l1_valid & snp_valid), 64'd0);
    check("ctl_vs_valid", 64'((ctl_clear | ctl_print) & (l1_valid | snp_valid)), 64'd0);
    if (hold_l1) begin
      check("l1_hold_valid", 64'(l1_valid), 64'd1);
      check("l1_hold_op", 64'(l1_op), 64'(h_l1_op));
      check("l1_hold_addr", 64'(l1_addr), 64'(h_l1_addr));
    end
    if (hold_snp) begin
      check("snp_hold_valid", 64'(snp_valid), 64'd1);
      check("snp_hold_op", 64'(snp_op), 64'(h_snp_op));
      check("snp_hold_addr", 64'(snp_addr), 64'(h_snp_addr));
    end
    if (l1_valid && l1_ready) begin
      consume({2'b00, l1_op}, l1_addr, 1'b1, ec);
      if (ec == 4'd1) m_wr = sat(m_wr);
      else if (ec == 4'd0 || ec == 4'd2) m_rd = sat(m_rd);
    end
    if (snp_valid && snp_ready) begin
      consume(4'({2'b00, snp_op} + 4'd3), snp_addr, 1'b1, ec);
      if (ec >= 4'd3 && ec <= 4'd6) m_snp = sat(m_snp);
    end
    if (ctl_clear) consume(4'd8, '0, 1'b0, ec);
    if (ctl_print) consume(4'd9, '0, 1'b0, ec);
    hold_l1    = l1_valid && !l1_ready;
    h_l1_op    = l1_op;
    h_l1_addr  = l1_addr;
    hold_snp   = snp_valid && !snp_ready;
    h_snp_op   = snp_op;
    h_snp_addr = snp_addr;
    if (cmd_valid && cmd_ready) begin
      acc = 1'b1;
      if (legal(cmd)) exp_q.push_back('{code: cmd, addr: cmd_addr});
      else m_err = sat(m_err);
    end
  endtask

  task automatic step();
    observe();
    @(posedge clk);
    @(negedge clk);
    l1_ready  = (l1_mode == 2) ? 1'($urandom_range(0, 1)) : (l1_mode == 1);
    snp_ready = (snp_mode == 2) ? 1'($urandom_range(0, 1)) : (snp_mode == 1);
  endtask

  task automatic send(input logic [3:0] c, input logic [ADDR_W-1:0] a);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_addr  = a;
    for (int i = 0; i < 300; i++) begin
      step();
      if (acc) break;
    end
    check("send_accepted", 64'(acc), 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic set_ready(input int mode);
    l1_mode   = mode;
    snp_mode  = mode;
    l1_ready  = (mode == 1);
    snp_ready = (mode == 1);
  endtask

  task automatic drain();
    set_ready(1);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (DEPTH + 4) step();
    check("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_l1_valid", 64'(l1_valid), 64'd0);
    check("rst_snp_valid", 64'(snp_valid), 64'd0);
    check("rst_ctl", 64'({ctl_clear, ctl_print}), 64'd0);
    check("rst_counters", 64'({rd_cnt, wr_cnt, snp_cnt, err_cnt}), 64'd0);
    m_rd  = 0;
    m_wr  = 0;
    m_snp = 0;
    m_err = 0;
    rst   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t3_codes [9];
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    cmd_addr = '0;
    set_ready(0);
    @(negedge clk);
    do_reset();

    // 1: single read, two-edge latency
    set_ready(1);
    send(4'd0, 32'h1000);
    check("t1_not_yet", 64'(l1_valid), 64'd0);
    step();
    check("t1_l1_valid", 64'(l1_valid), 64'd1);
    check("t1_l1_op", 64'(l1_op), 64'd0);
    check("t1_l1_addr", 64'(l1_addr), 64'h1000);
    drain();
    check("t1_rd_cnt", 64'(rd_cnt), 64'd1);

    // 2: snoops stalled then released
    set_ready(0);
    for (int i = 0; i < 4; i++) send(4'(3 + i), 32'(32'hA0 + i));
    repeat (5) step();
    check("t2_snp_valid", 64'(snp_valid), 64'd1);
    check("t2_snp_op", 64'(snp_op), 64'd0);
    check("t2_snp_addr", 64'(snp_addr), 64'hA0);
    drain();
    check("t2_snp_cnt", 64'(snp_cnt), 64'd4);

    // 3: fill the FIFO with both readies low
    t3_codes = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd2, 4'd3};
    set_ready(0);
    for (int i = 0; i < 9; i++) send(t3_codes[i], 32'(32'hB0 + i));
    check("t3_full", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    cmd = 4'd5;
    cmd_addr = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_no_push", 64'(acc), 64'd0);
    end
    cmd_valid = 1'b0;
    drain();

    // 4: mixed write, control pulses, illegal code
    set_ready(1);
    send(4'd1, 32'hC100);
    send(4'd8, 32'hC200);
    send(4'd2, 32'hC300);
    send(4'd9, 32'hC400);
    send(4'd7, 32'hC500);
    drain();
    check("t4_wr_cnt", 64'(wr_cnt), 64'd1);
    check("t4_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_rd_cnt", 64'(rd_cnt), 64'd6);
    check("t4_snp_cnt", 64'(snp_cnt), 64'd9);

    // 5: reset while stalled in L1_WAIT with three buffered
    set_ready(0);
    send(4'd0, 32'hD0);
    send(4'd1, 32'hD1);
    send(4'd2, 32'hD2);
    send(4'd4, 32'hD3);
    check("t5_stalled", 64'(l1_valid), 64'd1);
    do_reset();
    set_ready(1);
    step();
    check("t5_ready_after", 64'(cmd_ready), 64'd1);
    repeat (6) step();
    check("t5_l1_idle", 64'(l1_valid), 64'd0);
    check("t5_snp_idle", 64'(snp_valid), 64'd0);

    // 6: counter saturation
    set_ready(1);
    for (int i = 0; i < 20; i++) send(($urandom_range(0, 1) != 0) ? 4'd2 : 4'd0, $urandom);
    drain();
    check("t6_rd_sat", 64'(rd_cnt), 64'(CNT_MAX));

    // Randomized stream with random backpressure
    do_reset();
    set_ready(2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(4'($urandom_range(0, 15)), $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
